// File: rtl/wb_info_arbiter.sv
// rtl/wb_info_arbiter.sv - round-robin Wishbone B3 arbiter with cyc bus lock
// Optional hung-transfer watchdog enabled by defining WB_INFO_ARB_TIMEOUT_EN.
module wb_info_arbiter #(
  parameter int          NUM_MASTERS = 2,
  parameter int          AW          = 5,
  parameter logic [31:0] TIMEOUT     = 32'd255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_MASTERS*AW-1:0] m_adr_i,
  input  logic [NUM_MASTERS*32-1:0] m_dat_i,
  input  logic [NUM_MASTERS*4-1:0]  m_sel_i,
  input  logic [NUM_MASTERS-1:0]    m_cyc_i,
  input  logic [NUM_MASTERS-1:0]    m_stb_i,
  input  logic [NUM_MASTERS-1:0]    m_we_i,
  output logic [NUM_MASTERS-1:0]    m_ack_o,
  output logic [NUM_MASTERS-1:0]    m_err_o,
  output logic [NUM_MASTERS-1:0]    m_rty_o,
  output logic [31:0]               m_dat_o,
  output logic [AW-1:0]             s_adr_o,
  output logic [31:0]               s_dat_o,
  output logic [3:0]                s_sel_o,
  output logic                      s_cyc_o,
  output logic                      s_stb_o,
  output logic                      s_we_o,
  input  logic                      s_ack_i,
  input  logic                      s_err_i,
  input  logic                      s_rty_i,
  input  logic [31:0]               s_dat_i,
  output logic [NUM_MASTERS-1:0]    grant_o
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                   state, state_nxt;
  logic [NUM_MASTERS-1:0]   grant, grant_nxt;
  logic [1:0]               last, last_nxt;
  logic [1:0]               win;
  logic                     win_vld;
  logic [2:0]               sum;
  logic [3:0]               win_onehot;
  logic [3:0]               cyc_ext, grant_ext;
  logic [4*AW-1:0]          adr_ext;
  logic [4*32-1:0]          dat_ext;
  logic [4*4-1:0]           sel_ext;
  logic [3:0]               stb_ext, we_ext;
  logic                     owner_cyc, owner_stb;
  logic                     term;
  logic                     wd_fire;

  assign term       = s_ack_i | s_err_i | s_rty_i;
  assign owner_cyc  = |(m_cyc_i & grant);
  assign owner_stb  = |(m_stb_i & grant);
  assign win_onehot = 4'b0001 << win;
  assign grant_o    = grant;
  assign m_dat_o    = s_dat_i;

`ifdef WB_INFO_ARB_TIMEOUT_EN
  logic [15:0] wd_cnt;

  assign wd_fire = (state == BUSY) && (wd_cnt == TIMEOUT[15:0]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt <= '0;
    end else if (state != BUSY || wd_fire || !owner_stb || term) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 16'd1;
    end
  end
`else
  assign wd_fire = 1'b0;
`endif

  always_comb begin
    cyc_ext   = '0;
    stb_ext   = '0;
    we_ext    = '0;
    grant_ext = '0;
    adr_ext   = '0;
    dat_ext   = '0;
    sel_ext   = '0;
    cyc_ext[NUM_MASTERS-1:0]      = m_cyc_i;
    stb_ext[NUM_MASTERS-1:0]      = m_stb_i;
    we_ext[NUM_MASTERS-1:0]       = m_we_i;
    grant_ext[NUM_MASTERS-1:0]    = grant;
    adr_ext[NUM_MASTERS*AW-1:0]   = m_adr_i;
    dat_ext[NUM_MASTERS*32-1:0]   = m_dat_i;
    sel_ext[NUM_MASTERS*4-1:0]    = m_sel_i;
  end

  // Scan farthest-first so the requester nearest to last+1 is assigned last and wins.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    sum     = '0;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      sum = {1'b0, last} + 3'(k);
      if (sum >= 3'(NUM_MASTERS)) sum = sum - 3'(NUM_MASTERS);
      if (cyc_ext[sum[1:0]]) begin
        win     = sum[1:0];
        win_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      grant <= '0;
      last  <= 2'(NUM_MASTERS - 1);
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      last  <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    last_nxt  = last;
    s_adr_o   = '0;
    s_dat_o   = '0;
    s_sel_o   = '0;
    s_we_o    = 1'b0;
    case (state)
      IDLE: begin
        if (win_vld) begin
          state_nxt = BUSY;
          grant_nxt = win_onehot[NUM_MASTERS-1:0];
          last_nxt  = win;
        end
      end
      BUSY: begin
        if (!owner_cyc) begin
          state_nxt = IDLE;
          grant_nxt = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
    for (int k = 0; k < 4; k++) begin
      if (grant_ext[k]) begin
        s_adr_o = adr_ext[k*AW +: AW];
        s_dat_o = dat_ext[k*32 +: 32];
        s_sel_o = sel_ext[k*4 +: 4];
        s_we_o  = we_ext[k];
      end
    end
    // A watchdog firing takes the slave off the bus and substitutes its own err.
    s_cyc_o = owner_cyc & ~wd_fire;
    s_stb_o = owner_stb & ~wd_fire;
    m_ack_o = grant & {NUM_MASTERS{s_ack_i & ~wd_fire}};
    m_err_o = grant & {NUM_MASTERS{s_err_i | wd_fire}};
    m_rty_o = grant & {NUM_MASTERS{s_rty_i & ~wd_fire}};
  end

endmodule

// File: tb/tb_wb_info_arbiter.sv
// tb/tb_wb_info_arbiter.sv - directed and randomized checks of wb_info_arbiter
module tb_wb_info_arbiter;

  localparam int          N  = 2;
  localparam int          AW = 5;
  localparam logic [31:0] TO = 32'd4;

  logic              clk;
  logic              rst;
  logic [N*AW-1:0]   m_adr_i;
  logic [N*32-1:0]   m_dat_i;
  logic [N*4-1:0]    m_sel_i;
  logic [N-1:0]      m_cyc_i, m_stb_i, m_we_i;
  logic [N-1:0]      m_ack_o, m_err_o, m_rty_o;
  logic [31:0]       m_dat_o;
  logic [AW-1:0]     s_adr_o;
  logic [31:0]       s_dat_o;
  logic [3:0]        s_sel_o;
  logic              s_cyc_o, s_stb_o, s_we_o;
  logic              s_ack_i, s_err_i, s_rty_i;
  logic [31:0]       s_dat_i;
  logic [N-1:0]      grant_o;

  int checks = 0;
  int passed = 0;
  int mo, mlast, mcnt;

  wb_info_arbiter #(.NUM_MASTERS(N), .AW(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o), .m_dat_o(m_dat_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i), .s_dat_i(s_dat_i),
    .grant_o(grant_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_m(input int k, input bit cyc, input bit stb, input bit we,
                       input logic [AW-1:0] adr, input logic [31:0] dat);
    m_cyc_i[k] = cyc;
    m_stb_i[k] = stb;
    m_we_i[k]  = we;
    m_adr_i[k*AW +: AW] = adr;
    m_dat_i[k*32 +: 32] = dat;
    m_sel_i[k*4 +: 4]   = 4'hf;
  endtask

  function automatic bit wd_fire_model();
`ifdef WB_INFO_ARB_TIMEOUT_EN
    return (mo >= 0) && (mcnt == int'(TO));
`else
    return 1'b0;
`endif
  endfunction

  // Expected outputs from the owner index and the current inputs.
  task automatic model_check();
    logic [N-1:0]  eg, ea, ee, er;
    logic          fire, ec, es, ew;
    logic [AW-1:0] ead;
    logic [31:0]   edat;
    logic [3:0]    esel;
    eg = '0; ea = '0; ee = '0; er = '0;
    ec = 1'b0; es = 1'b0; ew = 1'b0; ead = '0; edat = '0; esel = '0;
    fire = wd_fire_model();
    if (mo >= 0) begin
      eg[mo] = 1'b1;
      ec     = m_cyc_i[mo] & ~fire;
      es     = m_stb_i[mo] & ~fire;
      ew     = m_we_i[mo];
      ead    = m_adr_i[mo*AW +: AW];
      edat   = m_dat_i[mo*32 +: 32];
      esel   = m_sel_i[mo*4 +: 4];
      ea[mo] = s_ack_i & ~fire;
      ee[mo] = s_err_i | fire;
      er[mo] = s_rty_i & ~fire;
    end
    check("rnd_grant", grant_o, eg);
    check("rnd_s_cyc", s_cyc_o, ec);
    check("rnd_s_stb", s_stb_o, es);
    check("rnd_s_we",  s_we_o,  ew);
    check("rnd_s_adr", s_adr_o, ead);
    check("rnd_s_dat", s_dat_o, edat);
    check("rnd_s_sel", s_sel_o, esel);
    check("rnd_m_ack", m_ack_o, ea);
    check("rnd_m_err", m_err_o, ee);
    check("rnd_m_rty", m_rty_o, er);
    check("rnd_m_dat", m_dat_o, s_dat_i);
  endtask

  // Advance the reference by one clock edge using the inputs currently applied.
  task automatic model_step();
    bit fire;
    fire = wd_fire_model();
    if (mo < 0) begin
      mcnt = 0;
      for (int k = 1; k <= N; k++) begin
        int idx;
        idx = (mlast + k) % N;
        if (m_cyc_i[idx]) begin
          mo    = idx;
          mlast = idx;
          break;
        end
      end
    end else begin
      if (fire) mcnt = 0;
      else if (m_stb_i[mo] && !(s_ack_i || s_err_i || s_rty_i)) mcnt = mcnt + 1;
      else mcnt = 0;
      if (!m_cyc_i[mo]) mo = -1;
    end
  endtask

  initial begin
    int errs;
    rst = 1'b0;
    m_adr_i = '0; m_dat_i = '0; m_sel_i = '0;
    m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
    s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0; s_dat_i = '0;

    // Reset state
    #2;
    check("rst_grant", grant_o, 2'b00);
    check("rst_s_cyc", s_cyc_o, 1'b0);
    check("rst_s_stb", s_stb_o, 1'b0);
    check("rst_m_ack", m_ack_o, 2'b00);
    check("rst_s_adr", s_adr_o, 5'h00);
    s_dat_i = 32'hdead_beef;
    #1;
    check("rst_m_dat", m_dat_o, 32'hdead_beef);
    @(negedge clk);
    rst = 1'b1;

    // Master 0 single read
    set_m(0, 1, 1, 0, 5'h03, 32'h0);
    @(negedge clk); #1;
    check("rd_grant", grant_o, 2'b01);
    check("rd_s_cyc", s_cyc_o, 1'b1);
    check("rd_s_adr", s_adr_o, 5'h03);
    check("rd_ack_wait", m_ack_o, 2'b00);
    s_ack_i = 1'b1; s_dat_i = 32'h0200_0000;
    #1;
    check("rd_ack", m_ack_o, 2'b01);
    check("rd_m_dat", m_dat_o, 32'h0200_0000);
    @(negedge clk);
    s_ack_i = 1'b0;
    set_m(0, 0, 0, 0, 5'h00, 32'h0);
    #1;
    check("rd_ack_once", m_ack_o, 2'b00);
    check("rd_cyc_drop", s_cyc_o, 1'b0);
    @(negedge clk); #1;
    check("rd_idle", grant_o, 2'b00);

    // Simultaneous requests from reset, release and re-grant
    rst = 1'b0; #1; rst = 1'b1;
    set_m(0, 1, 1, 1, 5'h01, 32'h1111_0000);
    set_m(1, 1, 1, 0, 5'h02, 32'h2222_0000);
    @(negedge clk); #1;
    check("rr_first", grant_o, 2'b01);
    check("rr_first_we", s_we_o, 1'b1);
    set_m(0, 0, 0, 0, 5'h00, 32'h0);
    @(negedge clk); #1;
    check("rr_gap", grant_o, 2'b00);
    @(negedge clk); #1;
    check("rr_second", grant_o, 2'b10);
    check("rr_second_adr", s_adr_o, 5'h02);
    set_m(1, 0, 0, 0, 5'h00, 32'h0);
    @(negedge clk); #1;
    check("rr_idle", grant_o, 2'b00);
    set_m(0, 1, 1, 0, 5'h01, 32'h0);
    set_m(1, 1, 1, 0, 5'h02, 32'h0);
    @(negedge clk); #1;
    check("rr_wrap", grant_o, 2'b01);
    set_m(0, 0, 0, 0, 5'h00, 32'h0);
    set_m(1, 0, 0, 0, 5'h00, 32'h0);
    @(negedge clk);

    // Master 1 bus lock across three reads while master 0 waits
    set_m(1, 1, 1, 0, 5'h04, 32'h0);
    @(negedge clk); #1;
    check("lock_grant", grant_o, 2'b10);
    set_m(0, 1, 1, 0, 5'h05, 32'h0);
    for (int i = 0; i < 3; i++) begin
      s_ack_i = 1'b1; s_dat_i = 32'h3000_0000 + i;
      #1;
      check("lock_hold", grant_o, 2'b10);
      check("lock_ack", m_ack_o, 2'b10);
      @(negedge clk);
    end
    s_ack_i = 1'b0;
    set_m(0, 0, 0, 0, 5'h00, 32'h0);

    // Slave error routed to owner only
    s_err_i = 1'b1;
    #1;
    check("err_route", m_err_o, 2'b10);
    check("err_no_ack", m_ack_o, 2'b00);
    @(negedge clk);
    s_err_i = 1'b0;

    // Silent slave
`ifdef WB_INFO_ARB_TIMEOUT_EN
    for (int i = 0; i < 6; i++) begin
      #1;
      check("wd_err", m_err_o, (i == 4) ? 2'b10 : 2'b00);
      check("wd_stb", s_stb_o, (i == 4) ? 1'b0 : 1'b1);
      check("wd_grant", grant_o, 2'b10);
      @(negedge clk);
    end
`else
    errs = 0;
    for (int i = 0; i < 1000; i++) begin
      #1;
      if (m_err_o != 2'b00) errs++;
      @(negedge clk);
    end
    check("nowd_err_count", errs, 0);
    check("nowd_grant", grant_o, 2'b10);
    check("nowd_stb", s_stb_o, 1'b1);
`endif

    // Asynchronous reset mid-transfer
    set_m(0, 1, 1, 0, 5'h06, 32'h0);
    #2;
    rst = 1'b0;
    #1;
    check("arst_grant", grant_o, 2'b00);
    check("arst_s_cyc", s_cyc_o, 1'b0);
    check("arst_s_stb", s_stb_o, 1'b0);
    check("arst_err", m_err_o, 2'b00);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    check("arst_prio", grant_o, 2'b01);

    // Randomized traffic against the reference model
    m_cyc_i = '0; m_stb_i = '0;
    @(negedge clk);
    rst = 1'b0; #1; rst = 1'b1;
    mo = -1; mlast = N - 1; mcnt = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(3) == 0) m_cyc_i[k] = ~m_cyc_i[k];
        m_stb_i[k] = m_cyc_i[k] & ($urandom_range(3) != 0);
        m_we_i[k]  = 1'($urandom_range(1));
        m_adr_i[k*AW +: AW] = AW'($urandom);
        m_dat_i[k*32 +: 32] = $urandom;
        m_sel_i[k*4 +: 4]   = 4'($urandom);
      end
      s_ack_i = ($urandom_range(99) < 45);
      s_err_i = ($urandom_range(99) < 8);
      s_rty_i = ($urandom_range(99) < 8);
      s_dat_i = $urandom;
      #1;
      model_check();
      model_step();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
